// File: rtl/mac_row_sequencer.sv
// mac_row_sequencer: produces one dot-product element.
// Accepts VEC_LEN operand pairs, accumulates their products modulo 2^ACC_W,
// then holds the result under a valid/ready handshake. Wrap-around is never
// saturated; it sets the sticky overflow flag for the current dot product.
module mac_row_sequencer #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned ACC_W   = 10,
  parameter int unsigned VEC_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              clear_o,
  output logic              ld_o,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              ovf_nxt;
  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  sum;
  logic              beat;

  // Product is zero-extended into a one-bit-wider sum so the carry out is visible.
  assign prod    = PROD_W'(a_in) * PROD_W'(b_in);
  assign sum     = SUM_W'(acc) + SUM_W'(prod);
  assign beat    = in_valid & in_ready;
  assign ld_o    = beat;
  assign acc_out = acc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and accumulator update rules.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = overflow;
    case (state)
      IDLE: begin
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        acc_nxt   = '0;
        cnt_nxt   = '0;
        ovf_nxt   = 1'b0;
        state_nxt = ACCUM;
      end
      ACCUM: begin
        if (beat) begin
          acc_nxt = sum[ACC_W-1:0];
          cnt_nxt = cnt + CNT_W'(1);
          if (sum[ACC_W]) ovf_nxt = 1'b1;
          if (cnt == LAST_CNT) state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Back-to-back start skips IDLE; start is ignored while stalled.
        if (out_ready) state_nxt = start ? CLEAR : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers and state-decoded outputs, registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      clear_o   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      overflow  <= ovf_nxt;
      out_valid <= (state_nxt == HOLD);
      in_ready  <= (state_nxt == ACCUM);
      clear_o   <= (state_nxt == CLEAR);
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_mac_row_sequencer.sv
// Bench for mac_row_sequencer: a VEC_LEN=4 instance for most scenarios and a
// VEC_LEN=8 instance for the overflow case. Expected results come from the
// plain arithmetic total of the operand products.
module tb_mac_row_sequencer;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned ACC_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, start8;
  logic [DATA_W-1:0] a_in, b_in;
  logic              in_valid, in_valid8;
  logic              out_ready, out_ready8;

  logic              in_ready, out_valid, clear_o, ld_o, overflow, busy;
  logic [ACC_W-1:0]  acc_out;
  logic              in_ready8, out_valid8, clear_o8, ld_o8, overflow8, busy8;
  logic [ACC_W-1:0]  acc_out8;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] va [16];
  logic [DATA_W-1:0] vb [16];
  int                nvec;

  always #5 clk = ~clk;

  mac_row_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .VEC_LEN(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready), .acc_out(acc_out),
    .out_valid(out_valid), .out_ready(out_ready), .clear_o(clear_o),
    .ld_o(ld_o), .overflow(overflow), .busy(busy)
  );

  mac_row_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .VEC_LEN(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid8), .in_ready(in_ready8), .acc_out(acc_out8),
    .out_valid(out_valid8), .out_ready(out_ready8), .clear_o(clear_o8),
    .ld_o(ld_o8), .overflow(overflow8), .busy(busy8)
  );

  // True (unwrapped) dot product of the loaded vector.
  function automatic int model_total();
    int t = 0;
    for (int i = 0; i < nvec; i++) t += int'(va[i]) * int'(vb[i]);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_basic();
    nvec = 4;
    for (int i = 0; i < 4; i++) begin
      va[i] = DATA_W'(i + 1);
      vb[i] = DATA_W'(i + 5);
    end
  endtask

  // Pulse start from IDLE; reports clear_o in the CLEAR cycle and the cycle after.
  task automatic do_start(output logic clr_first, output logic clr_second);
    start = 1'b1;
    tick();
    start = 1'b0;
    clr_first = clear_o;
    tick();
    clr_second = clear_o;
  endtask

  // Feed the loaded vector with optional random bubbles (1..max_bubble) before each beat.
  task automatic feed(input int max_bubble, output int lds, output int ld_bad, output int early_ov);
    int nb;
    lds = 0; ld_bad = 0; early_ov = 0;
    for (int i = 0; i < nvec; i++) begin
      nb = (max_bubble > 0) ? int'($urandom_range(max_bubble, 1)) : 0;
      for (int j = 0; j < nb; j++) begin
        in_valid = 1'b0;
        a_in = DATA_W'($urandom);
        b_in = DATA_W'($urandom);
        #1;
        if (ld_o) ld_bad++;
        if (out_valid) early_ov++;
        tick();
      end
      in_valid = 1'b1;
      a_in = va[i];
      b_in = vb[i];
      #1;
      if (ld_o) lds++;
      if (out_valid) early_ov++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Consume the held result and return to IDLE.
  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); start8 = 1'($urandom);
      in_valid = 1'($urandom); in_valid8 = 1'($urandom);
      out_ready = 1'($urandom); out_ready8 = 1'($urandom);
      a_in = DATA_W'($urandom); b_in = DATA_W'($urandom);
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (acc_out !== '0) begin failures++; $display("FAIL reset_acc got=%0d exp=0", acc_out); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (clear_o !== 1'b0) begin failures++; $display("FAIL reset_clear got=%b exp=0", clear_o); end
    checks++; if ({busy8, out_valid8, acc_out8} !== '0) begin failures++; $display("FAIL reset_dut8 got=%b/%b/%0d exp=0/0/0", busy8, out_valid8, acc_out8); end
    start = 1'b0; start8 = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0;
    out_ready = 1'b0; out_ready8 = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic c1, c2;
    int lds, bad, early, total;
    load_basic();
    total = model_total();
    do_start(c1, c2);
    checks++; if ({c1, c2} !== 2'b10) begin failures++; $display("FAIL basic_clear_pulse got=%b%b exp=10", c1, c2); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
    feed(0, lds, bad, early);
    checks++; if (lds !== 4 || early !== 0) begin failures++; $display("FAIL basic_ld got=%0d early_ov=%0d exp=4/0", lds, early); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    checks++; if (acc_out !== ACC_W'(total % 1024)) begin failures++; $display("FAIL basic_acc got=%0d exp=%0d", acc_out, total % 1024); end
    checks++; if (overflow !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL basic_ovf_ready got=%b/%b exp=0/0", overflow, in_ready); end
    release_result();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_release got=%b/%b exp=0/0", out_valid, busy); end
  endtask

  task automatic test_max_values();
    logic c1, c2;
    int lds, bad, early, total;
    nvec = 4;
    for (int i = 0; i < 4; i++) begin va[i] = 4'd15; vb[i] = 4'd15; end
    total = model_total();
    do_start(c1, c2);
    feed(0, lds, bad, early);
    checks++; if (acc_out !== ACC_W'(total % 1024) || out_valid !== 1'b1) begin failures++; $display("FAIL max4_acc got=%0d/%b exp=%0d/1", acc_out, out_valid, total % 1024); end
    checks++; if (overflow !== 1'(total >= 1024)) begin failures++; $display("FAIL max4_ovf got=%b exp=%b", overflow, total >= 1024); end
    release_result();
  endtask

  task automatic test_max8();
    int vv, total;
    for (int pass = 0; pass < 2; pass++) begin
      vv = (pass == 0) ? 15 : 1;
      total = 8 * vv * vv;
      if (pass == 0) begin
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
      end
      checks++; if (clear_o8 !== 1'b1) begin failures++; $display("FAIL max8_clear pass=%0d got=%b exp=1", pass, clear_o8); end
      tick();
      for (int i = 0; i < 8; i++) begin
        in_valid8 = 1'b1;
        a_in = DATA_W'(vv);
        b_in = DATA_W'(vv);
        tick();
      end
      in_valid8 = 1'b0;
      checks++; if (out_valid8 !== 1'b1 || acc_out8 !== ACC_W'(total % 1024)) begin failures++; $display("FAIL max8_acc pass=%0d got=%0d/%b exp=%0d/1", pass, acc_out8, out_valid8, total % 1024); end
      checks++; if (overflow8 !== 1'(total >= 1024)) begin failures++; $display("FAIL max8_ovf pass=%0d got=%b exp=%b", pass, overflow8, total >= 1024); end
      out_ready8 = 1'b1;
      start8 = (pass == 0);
      tick();
      out_ready8 = 1'b0;
      start8 = 1'b0;
    end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL max8_idle got=%b exp=0", busy8); end
  endtask

  task automatic test_bubbles();
    logic c1, c2;
    int lds, bad, early, total;
    load_basic();
    total = model_total();
    do_start(c1, c2);
    feed(3, lds, bad, early);
    checks++; if (lds !== 4 || bad !== 0) begin failures++; $display("FAIL bubble_ld got=%0d bad=%0d exp=4/0", lds, bad); end
    checks++; if (early !== 0 || out_valid !== 1'b1) begin failures++; $display("FAIL bubble_valid got=%0d/%b exp=0/1", early, out_valid); end
    checks++; if (acc_out !== ACC_W'(total % 1024)) begin failures++; $display("FAIL bubble_acc got=%0d exp=%0d", acc_out, total % 1024); end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic c1, c2;
    int lds, bad, early, total, unstable;
    load_basic();
    total = model_total();
    do_start(c1, c2);
    feed(0, lds, bad, early);
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      start = 1'($urandom);
      tick();
      if (out_valid !== 1'b1 || acc_out !== ACC_W'(total % 1024) || clear_o !== 1'b0) unstable++;
    end
    checks++; if (unstable !== 0) begin failures++; $display("FAIL hold_stable got=%0d unstable cycles exp=0", unstable); end
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    checks++; if (clear_o !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_clear got=%b/%b/%b exp=1/0/1", clear_o, out_valid, busy); end
    tick();
    for (int i = 0; i < 4; i++) begin va[i] = 4'd1; vb[i] = 4'd1; end
    total = model_total();
    feed(0, lds, bad, early);
    checks++; if (acc_out !== ACC_W'(total % 1024) || overflow !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_acc got=%0d/%b/%b exp=%0d/0/1", acc_out, overflow, out_valid, total % 1024); end
    release_result();
  endtask

  task automatic test_mid_reset();
    logic c1, c2;
    int lds, bad, early, total, stray;
    nvec = 2;
    va[0] = 4'd9; vb[0] = 4'd7; va[1] = 4'd3; vb[1] = 4'd11;
    do_start(c1, c2);
    feed(0, lds, bad, early);
    checks++; if (in_ready !== 1'b1 || acc_out !== ACC_W'(model_total())) begin failures++; $display("FAIL midrst_partial got=%b/%0d exp=1/%0d", in_ready, acc_out, model_total()); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || acc_out !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL midrst_state got=%b/%0d/%b/%b exp=0/0/0/0", busy, acc_out, out_valid, in_ready); end
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom);
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    in_valid = 1'b0;
    checks++; if (stray !== 0) begin failures++; $display("FAIL midrst_stray got=%0d exp=0", stray); end
    load_basic();
    total = model_total();
    do_start(c1, c2);
    feed(0, lds, bad, early);
    checks++; if (acc_out !== ACC_W'(total % 1024) || out_valid !== 1'b1) begin failures++; $display("FAIL midrst_fresh got=%0d/%b exp=%0d/1", acc_out, out_valid, total % 1024); end
    release_result();
  endtask

  task automatic test_random();
    logic c1, c2;
    int lds, bad, early, total;
    for (int it = 0; it < 8; it++) begin
      nvec = 4;
      for (int i = 0; i < 4; i++) begin
        va[i] = DATA_W'($urandom);
        vb[i] = DATA_W'($urandom);
      end
      total = model_total();
      do_start(c1, c2);
      feed(int'($urandom_range(2, 0)), lds, bad, early);
      checks++; if (acc_out !== ACC_W'(total % 1024) || overflow !== 1'(total >= 1024) || out_valid !== 1'b1 || early !== 0) begin
        failures++; $display("FAIL random_%0d got=%0d/%b/%b exp=%0d/%b/1", it, acc_out, overflow, out_valid, total % 1024, total >= 1024);
      end
      release_result();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; start8 = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0;
    out_ready = 1'b0; out_ready8 = 1'b0; a_in = '0; b_in = '0;
    nvec = 0;
    test_reset();
    test_basic();
    test_max_values();
    test_max8();
    test_bubbles();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
